// File: rtl/if_port_arbiter_pkg.sv
// Shared types and config-word layout for the host port arbiter.
package if_pkg;

   localparam int unsigned PORT_WIDTH_DEF = 128;
   localparam int unsigned LEN_WIDTH_DEF  = 16;
   localparam int unsigned NUM_REQ_DEF    = 4;

   // Config word field offsets for the default length width
   localparam int unsigned LEN_LSB = 0;
   localparam int unsigned DIR_BIT = LEN_LSB + LEN_WIDTH_DEF;
   localparam int unsigned ID_LSB  = DIR_BIT + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CFG  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } arb_state_e;

   // Direction bit position for an arbitrary length field width
   function automatic int unsigned dir_bit_for(input int unsigned len_width);
      return LEN_LSB + len_width;
   endfunction

endpackage

// File: rtl/if_port_arbiter_if.sv
// Client request/data handshakes plus port-side stage signals.
interface if_port_arbiter_if
   import if_pkg::*;
#(
   parameter int unsigned PORT_WIDTH = PORT_WIDTH_DEF,
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
);
   logic [NUM_REQ-1:0]            req_val;
   logic [NUM_REQ-1:0]            req_rdy;
   logic [NUM_REQ-1:0]            req_dir;
   logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
   logic [NUM_REQ-1:0]            cli_wr_val;
   logic [NUM_REQ-1:0]            cli_wr_rdy;
   logic [NUM_REQ*PORT_WIDTH-1:0] cli_wr_data;
   logic [NUM_REQ-1:0]            cli_rd_val;
   logic [NUM_REQ-1:0]            cli_rd_rdy;
   logic [PORT_WIDTH-1:0]         cli_rd_data;
   logic                          O_config_req;
   logic [PORT_WIDTH-1:0]         port_cfg_data;
   logic                          port_cfg_rdy;
   logic                          O_switch_rdwr;
   logic                          port_wr_val;
   logic                          port_wr_rdy;
   logic [PORT_WIDTH-1:0]         port_wr_data;
   logic                          port_rd_val;
   logic                          port_rd_rdy;
   logic [PORT_WIDTH-1:0]         port_rd_data;

   // Arbiter side
   modport slave (
      input  req_val, req_dir, req_len, cli_wr_val, cli_wr_data, cli_rd_rdy,
             port_cfg_rdy, port_wr_rdy, port_rd_val, port_rd_data,
      output req_rdy, cli_wr_rdy, cli_rd_val, cli_rd_data, O_config_req,
             port_cfg_data, O_switch_rdwr, port_wr_val, port_wr_data, port_rd_rdy
   );

   // Clients and port stage side
   modport master (
      output req_val, req_dir, req_len, cli_wr_val, cli_wr_data, cli_rd_rdy,
             port_cfg_rdy, port_wr_rdy, port_rd_val, port_rd_data,
      input  req_rdy, cli_wr_rdy, cli_rd_val, cli_rd_data, O_config_req,
             port_cfg_data, O_switch_rdwr, port_wr_val, port_wr_data, port_rd_rdy
   );

endinterface

// File: rtl/if_port_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               found
);

   logic [ID_W-1:0] pos;

   // Scan from ptr upward; the first hit wins
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pos = ID_W'((32'(ptr) + i) % NUM_REQ);
         if (!found && req[pos]) begin
            found    = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

endmodule

// File: rtl/if_port_arbiter.sv
// Shares the bidirectional host port among NUM_REQ clients, one transfer at a time.
module if_port_arbiter
   import if_pkg::*;
#(
   parameter int unsigned PORT_WIDTH = PORT_WIDTH_DEF,
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
   parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF,
   parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   if_port_arbiter_if.slave     bus,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id
);

   localparam int unsigned DIR_POS = dir_bit_for(LEN_WIDTH);
   localparam int unsigned ID_POS  = DIR_POS + 1;

   arb_state_e             state_q, state_d;
   logic [ID_W-1:0]        rr_ptr_q;
   logic [LEN_WIDTH-1:0]   cnt_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [ID_W-1:0]        id_q;
   logic                   dir_q;
   logic [NUM_REQ-1:0]     req_rdy_q;
   logic                   word_done;

   logic [NUM_REQ-1:0]     arb_gnt;
   logic [ID_W-1:0]        arb_idx;
   logic                   arb_found;
   logic [ID_W-1:0]        rr_ptr_nxt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req   (bus.req_val),
      .ptr   (rr_ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .found (arb_found)
   );

   assign rr_ptr_nxt  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
   assign bus.req_rdy = req_rdy_q;
   assign busy        = (state_q != IDLE);
   assign grant_id    = id_q;

   // State, grant latch and word counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         id_q      <= '0;
         dir_q     <= 1'b0;
         req_rdy_q <= '0;
      end else begin
         state_q   <= state_d;
         req_rdy_q <= '0;
         case (state_q)
            IDLE: begin
               if (arb_found) begin
                  id_q      <= arb_idx;
                  dir_q     <= bus.req_dir[arb_idx];
                  len_q     <= bus.req_len[32'(arb_idx)*LEN_WIDTH +: LEN_WIDTH];
                  req_rdy_q <= arb_gnt;
                  rr_ptr_q  <= rr_ptr_nxt;
               end
            end
            CFG:     cnt_q <= '0;
            XFER:    if (word_done) cnt_q <= cnt_q + LEN_WIDTH'(1);
            default: ;
         endcase
      end
   end

   // Next state and port/client steering on the latched grant
   always_comb begin
      state_d           = state_q;
      word_done         = 1'b0;
      bus.O_config_req  = 1'b0;
      bus.port_cfg_data = '0;
      bus.O_switch_rdwr = 1'b0;
      bus.port_wr_val   = 1'b0;
      bus.port_wr_data  = '0;
      bus.port_rd_rdy   = 1'b0;
      bus.cli_wr_rdy    = '0;
      bus.cli_rd_val    = '0;
      bus.cli_rd_data   = '0;
      case (state_q)
         IDLE: begin
            if (arb_found) state_d = CFG;
         end
         CFG: begin
            bus.O_config_req                        = 1'b1;
            bus.port_cfg_data[LEN_LSB +: LEN_WIDTH] = len_q;
            bus.port_cfg_data[DIR_POS]              = dir_q;
            bus.port_cfg_data[ID_POS +: ID_W]       = id_q;
            if (bus.port_cfg_rdy) state_d = XFER;
         end
         XFER: begin
            if (dir_q) begin
               bus.O_switch_rdwr    = 1'b1;
               bus.port_wr_val      = bus.cli_wr_val[id_q];
               bus.cli_wr_rdy[id_q] = bus.port_wr_rdy;
               bus.port_wr_data     = bus.cli_wr_data[32'(id_q)*PORT_WIDTH +: PORT_WIDTH];
               word_done            = bus.cli_wr_val[id_q] & bus.port_wr_rdy;
            end else begin
               bus.cli_rd_val[id_q] = bus.port_rd_val;
               bus.port_rd_rdy      = bus.cli_rd_rdy[id_q];
               bus.cli_rd_data      = bus.port_rd_data;
               word_done            = bus.port_rd_val & bus.cli_rd_rdy[id_q];
            end
            if (word_done && (cnt_q == len_q)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_if_port_arbiter.sv
// Directed scenario bench for if_port_arbiter.
module tb_if_port_arbiter;
   import if_pkg::*;

   localparam int unsigned PW = 128;
   localparam int unsigned NR = 4;
   localparam int unsigned LW = 16;
   localparam int unsigned IW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          busy;
   logic [IW-1:0] grant_id;
   int            pass_cnt  = 0;
   int            total_cnt = 0;

   if_port_arbiter_if #(.PORT_WIDTH(PW), .NUM_REQ(NR), .LEN_WIDTH(LW)) bus ();

   if_port_arbiter #(
      .PORT_WIDTH (PW),
      .NUM_REQ    (NR),
      .LEN_WIDTH  (LW),
      .ID_W       (IW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   // Expected config word built from the documented field offsets
   function automatic logic [PW-1:0] cfg_word(input int id, input bit dir, input int len);
      logic [PW-1:0] w;
      w = '0;
      w[LEN_LSB +: LW] = LW'(len);
      w[DIR_BIT]       = dir;
      w[ID_LSB +: IW]  = IW'(id);
      return w;
   endfunction

   task automatic clear_inputs();
      bus.req_val      = '0;
      bus.req_dir      = '0;
      bus.req_len      = '0;
      bus.cli_wr_val   = '0;
      bus.cli_wr_data  = '0;
      bus.cli_rd_rdy   = '0;
      bus.port_cfg_rdy = 1'b0;
      bus.port_wr_rdy  = 1'b0;
      bus.port_rd_val  = 1'b0;
      bus.port_rd_data = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      bus.req_val = 4'hF;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else pass_cnt++;
      total_cnt++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id got %0d exp 0", grant_id); else pass_cnt++;
      total_cnt++; if (bus.req_rdy !== 4'h0) $display("FAIL rst_req_rdy got %h exp 0", bus.req_rdy); else pass_cnt++;
      total_cnt++; if (bus.O_config_req !== 1'b0) $display("FAIL rst_cfg_req got %0b exp 0", bus.O_config_req); else pass_cnt++;
      total_cnt++; if (bus.O_switch_rdwr !== 1'b0) $display("FAIL rst_switch got %0b exp 0", bus.O_switch_rdwr); else pass_cnt++;
      total_cnt++; if (bus.port_cfg_data !== '0) $display("FAIL rst_cfg_data got %h exp 0", bus.port_cfg_data); else pass_cnt++;
      total_cnt++; if (bus.port_wr_val !== 1'b0) $display("FAIL rst_wr_val got %0b exp 0", bus.port_wr_val); else pass_cnt++;
      total_cnt++; if (bus.cli_rd_val !== 4'h0) $display("FAIL rst_rd_val got %h exp 0", bus.cli_rd_val); else pass_cnt++;
      total_cnt++; if (bus.port_wr_data !== '0) $display("FAIL rst_wr_data got %h exp 0", bus.port_wr_data); else pass_cnt++;
      bus.req_val = '0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int g    = 0;
      int cyc  = 0;
      int last = 0;
      int n    = 0;
      bus.req_val      = 4'hF;
      bus.port_cfg_rdy = 1'b1;
      bus.port_rd_val  = 1'b1;
      bus.cli_rd_rdy   = 4'hF;
      for (int c = 0; c < 40 && g < 5; c++) begin
         @(negedge clk);
         cyc++;
         if (bus.req_rdy !== 4'h0) begin
            total_cnt++; if (bus.req_rdy !== 4'(1 << exp_order[g])) $display("FAIL rr_req_rdy[%0d] got %h exp %h", g, bus.req_rdy, 4'(1 << exp_order[g])); else pass_cnt++;
            total_cnt++; if (grant_id !== IW'(exp_order[g])) $display("FAIL rr_grant_id[%0d] got %0d exp %0d", g, grant_id, exp_order[g]); else pass_cnt++;
            if (g > 0) begin
               total_cnt++; if (cyc - last !== 4) $display("FAIL rr_spacing[%0d] got %0d exp 4", g, cyc - last); else pass_cnt++;
            end
            last = cyc;
            g++;
         end
      end
      total_cnt++; if (g !== 5) $display("FAIL rr_grant_count got %0d exp 5", g); else pass_cnt++;
      bus.req_val = '0;
      while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      total_cnt++; if (busy !== 1'b0) $display("FAIL rr_drain got busy %0b exp 0", busy); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_single_fetch();
      bus.req_val[1]      = 1'b1;
      bus.req_dir[1]      = 1'b0;
      bus.req_len[16 +: 16] = 16'd3;
      @(negedge clk);
      total_cnt++; if (bus.req_rdy !== 4'b0010) $display("FAIL fetch_req_rdy got %h exp 2", bus.req_rdy); else pass_cnt++;
      total_cnt++; if (bus.O_config_req !== 1'b1) $display("FAIL fetch_cfg_req got %0b exp 1", bus.O_config_req); else pass_cnt++;
      total_cnt++; if (bus.port_cfg_data !== cfg_word(1, 1'b0, 3)) $display("FAIL fetch_cfg_word got %h exp %h", bus.port_cfg_data, cfg_word(1, 1'b0, 3)); else pass_cnt++;
      total_cnt++; if (grant_id !== 2'd1) $display("FAIL fetch_grant_id got %0d exp 1", grant_id); else pass_cnt++;
      bus.req_val = '0;
      bus.req_len[16 +: 16] = 16'd9;
      @(negedge clk);
      total_cnt++; if (bus.O_config_req !== 1'b1) $display("FAIL fetch_cfg_stall got %0b exp 1", bus.O_config_req); else pass_cnt++;
      total_cnt++; if (bus.req_rdy !== 4'h0) $display("FAIL fetch_rdy_pulse got %h exp 0", bus.req_rdy); else pass_cnt++;
      total_cnt++; if (bus.port_cfg_data !== cfg_word(1, 1'b0, 3)) $display("FAIL fetch_cfg_hold got %h exp %h", bus.port_cfg_data, cfg_word(1, 1'b0, 3)); else pass_cnt++;
      bus.port_cfg_rdy = 1'b1;
      @(negedge clk);
      bus.port_cfg_rdy = 1'b0;
      total_cnt++; if (bus.O_config_req !== 1'b0) $display("FAIL fetch_cfg_drop got %0b exp 0", bus.O_config_req); else pass_cnt++;
      total_cnt++; if (bus.O_switch_rdwr !== 1'b0) $display("FAIL fetch_switch got %0b exp 0", bus.O_switch_rdwr); else pass_cnt++;
      bus.cli_rd_rdy = 4'b0010;
      for (int w = 0; w < 4; w++) begin
         if (w == 2) begin
            bus.port_rd_val = 1'b0;
            #1;
            total_cnt++; if (bus.cli_rd_val !== 4'h0) $display("FAIL fetch_stall_val got %h exp 0", bus.cli_rd_val); else pass_cnt++;
            @(negedge clk);
         end
         bus.port_rd_val  = 1'b1;
         bus.port_rd_data = PW'(16 + w);
         #1;
         total_cnt++; if (bus.cli_rd_val !== 4'b0010) $display("FAIL fetch_rd_val[%0d] got %h exp 2", w, bus.cli_rd_val); else pass_cnt++;
         total_cnt++; if (bus.cli_rd_data !== PW'(16 + w)) $display("FAIL fetch_rd_data[%0d] got %h exp %h", w, bus.cli_rd_data, 16 + w); else pass_cnt++;
         total_cnt++; if (bus.port_rd_rdy !== 1'b1) $display("FAIL fetch_rd_rdy[%0d] got %0b exp 1", w, bus.port_rd_rdy); else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++; if (busy !== 1'b1) $display("FAIL fetch_done_busy got %0b exp 1", busy); else pass_cnt++;
      total_cnt++; if (bus.cli_rd_val !== 4'h0) $display("FAIL fetch_done_val got %h exp 0", bus.cli_rd_val); else pass_cnt++;
      total_cnt++; if (bus.port_rd_rdy !== 1'b0) $display("FAIL fetch_done_rdy got %0b exp 0", bus.port_rd_rdy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL fetch_idle got %0b exp 0", busy); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_write_back();
      int  idx = 0;
      int  c   = 0;
      bit  rdy;
      for (int k = 0; k < 4; k++) bus.cli_wr_data[k*PW +: PW] = PW'(32'hDEAD_0000 + k);
      bus.cli_wr_val       = 4'hF;
      bus.port_cfg_rdy     = 1'b1;
      bus.req_val[2]       = 1'b1;
      bus.req_dir[2]       = 1'b1;
      bus.req_len[32 +: 16] = 16'd7;
      @(negedge clk);
      total_cnt++; if (bus.port_cfg_data !== cfg_word(2, 1'b1, 7)) $display("FAIL wb_cfg_word got %h exp %h", bus.port_cfg_data, cfg_word(2, 1'b1, 7)); else pass_cnt++;
      total_cnt++; if (bus.O_switch_rdwr !== 1'b0) $display("FAIL wb_switch_cfg got %0b exp 0", bus.O_switch_rdwr); else pass_cnt++;
      bus.req_val = '0;
      @(negedge clk);
      while (idx < 8 && c < 40) begin
         rdy = (c % 2) == 1;
         bus.cli_wr_data[2*PW +: PW] = PW'(32'hA0 + idx);
         bus.port_wr_rdy = rdy;
         #1;
         total_cnt++; if (bus.O_switch_rdwr !== 1'b1) $display("FAIL wb_switch[%0d] got %0b exp 1", c, bus.O_switch_rdwr); else pass_cnt++;
         total_cnt++; if (bus.port_wr_val !== 1'b1) $display("FAIL wb_wr_val[%0d] got %0b exp 1", c, bus.port_wr_val); else pass_cnt++;
         total_cnt++; if (bus.port_wr_data !== PW'(32'hA0 + idx)) $display("FAIL wb_wr_data[%0d] got %h exp %h", c, bus.port_wr_data, 32'hA0 + idx); else pass_cnt++;
         total_cnt++; if (bus.cli_wr_rdy !== (rdy ? 4'b0100 : 4'b0000)) $display("FAIL wb_cli_rdy[%0d] got %h exp %h", c, bus.cli_wr_rdy, rdy ? 4'b0100 : 4'b0000); else pass_cnt++;
         if (rdy) idx++;
         c++;
         @(negedge clk);
      end
      total_cnt++; if (bus.O_switch_rdwr !== 1'b0) $display("FAIL wb_done_switch got %0b exp 0", bus.O_switch_rdwr); else pass_cnt++;
      total_cnt++; if (bus.port_wr_val !== 1'b0) $display("FAIL wb_done_val got %0b exp 0", bus.port_wr_val); else pass_cnt++;
      total_cnt++; if (bus.cli_wr_rdy !== 4'h0) $display("FAIL wb_done_rdy got %h exp 0", bus.cli_wr_rdy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL wb_idle got %0b exp 0", busy); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_boundary_len();
      int n = 0;
      bus.port_cfg_rdy      = 1'b1;
      bus.port_rd_val       = 1'b1;
      bus.port_rd_data      = PW'(32'h5A5A);
      bus.cli_rd_rdy        = 4'b0001;
      bus.req_val[0]        = 1'b1;
      bus.req_dir[0]        = 1'b0;
      bus.req_len[0 +: 16]  = 16'hFFFF;
      @(negedge clk);
      total_cnt++; if (bus.port_cfg_data !== cfg_word(0, 1'b0, 16'hFFFF)) $display("FAIL max_cfg_word got %h exp %h", bus.port_cfg_data, cfg_word(0, 1'b0, 16'hFFFF)); else pass_cnt++;
      bus.req_val = '0;
      @(negedge clk);
      while (bus.cli_rd_val[0] === 1'b1 && n < 70000) begin
         n++;
         @(negedge clk);
      end
      total_cnt++; if (n !== 65536) $display("FAIL max_handshakes got %0d exp 65536", n); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL max_done_busy got %0b exp 1", busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL max_idle got %0b exp 0", busy); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_reset_mid_xfer();
      int n = 0;
      bus.port_cfg_rdy      = 1'b1;
      bus.port_wr_rdy       = 1'b1;
      bus.cli_wr_val        = 4'b0100;
      bus.cli_wr_data[2*PW +: PW] = PW'(32'hBEEF);
      bus.req_val[2]        = 1'b1;
      bus.req_dir[2]        = 1'b1;
      bus.req_len[32 +: 16] = 16'd7;
      @(negedge clk);
      bus.req_val = '0;
      @(negedge clk);
      total_cnt++; if (bus.port_wr_val !== 1'b1) $display("FAIL rmx_wr_val got %0b exp 1", bus.port_wr_val); else pass_cnt++;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL rmx_busy got %0b exp 0", busy); else pass_cnt++;
      total_cnt++; if (grant_id !== 2'd0) $display("FAIL rmx_grant_id got %0d exp 0", grant_id); else pass_cnt++;
      total_cnt++; if (bus.O_switch_rdwr !== 1'b0) $display("FAIL rmx_switch got %0b exp 0", bus.O_switch_rdwr); else pass_cnt++;
      total_cnt++; if (bus.port_wr_val !== 1'b0) $display("FAIL rmx_wr_val_rst got %0b exp 0", bus.port_wr_val); else pass_cnt++;
      total_cnt++; if (bus.cli_wr_rdy !== 4'h0) $display("FAIL rmx_cli_rdy got %h exp 0", bus.cli_wr_rdy); else pass_cnt++;
      total_cnt++; if (bus.port_wr_data !== '0) $display("FAIL rmx_wr_data got %h exp 0", bus.port_wr_data); else pass_cnt++;
      rst_n = 1'b1;
      bus.req_val[2] = 1'b1;
      @(negedge clk);
      total_cnt++; if (bus.req_rdy !== 4'b0100) $display("FAIL rmx_regrant got %h exp 4", bus.req_rdy); else pass_cnt++;
      total_cnt++; if (bus.port_cfg_data !== cfg_word(2, 1'b1, 7)) $display("FAIL rmx_cfg_word got %h exp %h", bus.port_cfg_data, cfg_word(2, 1'b1, 7)); else pass_cnt++;
      bus.req_val = '0;
      @(negedge clk);
      while (bus.port_wr_val === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      total_cnt++; if (n !== 8) $display("FAIL rmx_words got %0d exp 8", n); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL rmx_idle got %0b exp 0", busy); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_late_request();
      int n = 0;
      bus.port_cfg_rdy      = 1'b1;
      bus.port_wr_rdy       = 1'b1;
      bus.cli_wr_val        = 4'b1000;
      bus.req_val[3]        = 1'b1;
      bus.req_dir[3]        = 1'b1;
      bus.req_len[48 +: 16] = 16'd3;
      @(negedge clk);
      total_cnt++; if (grant_id !== 2'd3) $display("FAIL late_grant3 got %0d exp 3", grant_id); else pass_cnt++;
      bus.req_val = '0;
      @(negedge clk);
      for (int w = 0; w < 4; w++) begin
         bus.cli_wr_data[3*PW +: PW] = PW'(32'h30 + w);
         if (w == 1) begin
            bus.req_val[0]       = 1'b1;
            bus.req_dir[0]       = 1'b0;
            bus.req_len[0 +: 16] = 16'd0;
         end
         #1;
         total_cnt++; if (bus.port_wr_data !== PW'(32'h30 + w)) $display("FAIL late_wr_data[%0d] got %h exp %h", w, bus.port_wr_data, 32'h30 + w); else pass_cnt++;
         total_cnt++; if (grant_id !== 2'd3) $display("FAIL late_owner[%0d] got %0d exp 3", w, grant_id); else pass_cnt++;
         total_cnt++; if (bus.req_rdy !== 4'h0) $display("FAIL late_no_preempt[%0d] got %h exp 0", w, bus.req_rdy); else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++; if (bus.req_rdy !== 4'h0 || busy !== 1'b1) $display("FAIL late_done got rdy %h busy %0b exp 0/1", bus.req_rdy, busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.req_rdy !== 4'h0 || busy !== 1'b0) $display("FAIL late_idle got rdy %h busy %0b exp 0/0", bus.req_rdy, busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.req_rdy !== 4'b0001) $display("FAIL late_grant0 got %h exp 1", bus.req_rdy); else pass_cnt++;
      total_cnt++; if (grant_id !== 2'd0) $display("FAIL late_grant_id got %0d exp 0", grant_id); else pass_cnt++;
      bus.req_val     = '0;
      bus.cli_wr_val  = '0;
      bus.port_rd_val = 1'b1;
      bus.cli_rd_rdy  = 4'b0001;
      while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      total_cnt++; if (busy !== 1'b0) $display("FAIL late_drain got busy %0b exp 0", busy); else pass_cnt++;
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_round_robin();
      test_single_fetch();
      test_write_back();
      test_boundary_len();
      test_reset_mid_xfer();
      test_late_request();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
